intra_neighbour_fetch: RTL and testbench

- Sequential neighbour-pixel fetcher for intra prediction. For one block, it gathers the top row (including top-right), the left column and the top-left corner pixel.
- Pixels come from the reconstructed-frame memory through a single read port with 1-cycle latency. It does not use a full-frame array port.
- Supports 4x4, 8x8 and 16x16 blocks, selected per request. Computes availability flags and applies H.264 substitution rules: default fill, and top-right replication.
- Sits between the reconstruction buffer and the intra mode predictors; one request per start/done handshake.

---
 rtl/intra_neighbour_fetch.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_intra_neighbour_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/intra_neighbour_fetch.sv
// Sequential neighbour-pixel fetcher for intra prediction.
// Gathers the top row (with top-right), the left column and the top-left
// corner of one 4x4/8x8/16x16 block through a 1-cycle-latency read port,
// substituting DEFAULT_PIX for unavailable neighbours and replicating
// top[N-1] when the top-right is unavailable.
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   start_i                  request strobe, accepted only when idle
//   blk_row_i, blk_col_i     pixel position of the block's top-left sample
//   blk_size_i               0=4x4, 1=8x8, 2/3=16x16
//   tr_avail_i               decode-order top-right availability
//   mem_rd_o, mem_addr_o     read strobe and address (row*FRAME_W+col)
//   mem_rdata_i              read data, valid the cycle after mem_rd_o
//   busy_o, done_o           fetch in progress / one-cycle completion pulse
//   top_pix_o                2*MAX_BLK entries, entry j at [j*PIX_W +: PIX_W]
//   left_pix_o               MAX_BLK entries
//   topleft_pix_o            corner pixel
//   avail_o                  {topleft, left, top}
module intra_neighbour_fetch #(
    parameter int unsigned PIX_W       = 8,
    parameter int unsigned FRAME_W     = 1280,
    parameter int unsigned FRAME_H     = 720,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned MAX_BLK     = 16,
    parameter int unsigned DEFAULT_PIX = 128
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         start_i,
    input  logic [15:0]                  blk_row_i,
    input  logic [15:0]                  blk_col_i,
    input  logic [1:0]                   blk_size_i,
    input  logic                         tr_avail_i,
    output logic                         mem_rd_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    input  logic [PIX_W-1:0]             mem_rdata_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [2*MAX_BLK*PIX_W-1:0]   top_pix_o,
    output logic [MAX_BLK*PIX_W-1:0]     left_pix_o,
    output logic [PIX_W-1:0]             topleft_pix_o,
    output logic [2:0]                   avail_o
);

    localparam int unsigned TOP_N  = 2 * MAX_BLK;
    localparam int unsigned CNT_W  = $clog2(MAX_BLK);
    localparam int unsigned TIDX_W = $clog2(TOP_N);

    // Elaboration guard: the address port must cover the whole frame.
    if (FRAME_W * FRAME_H > (64'd1 << ADDR_W)) begin : g_addr_w_check
        $error("ADDR_W too narrow for FRAME_W*FRAME_H");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CORNER, S_TOP, S_TR, S_LEFT, S_DRAIN, S_DONE
    } state_t;

    // First phase at or after p that actually has reads to issue.
    function automatic state_t first_phase(state_t p, logic tl, logic t, logic tr, logic l);
        state_t s;
        s = p;
        if (s == S_CORNER && !tl) s = S_TOP;
        if (s == S_TOP    && !t)  s = S_TR;
        if (s == S_TR     && !tr) s = S_LEFT;
        if (s == S_LEFT   && !l)  s = S_DRAIN;
        return s;
    endfunction

    function automatic state_t succ_phase(state_t p);
        case (p)
            S_CORNER: return S_TOP;
            S_TOP:    return S_TR;
            S_TR:     return S_LEFT;
            default:  return S_DRAIN;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         row_q, row_d, col_q, col_d;
    logic [TIDX_W-1:0]   n_q, n_d;
    logic                f_top_q, f_top_d, f_left_q, f_left_d;
    logic                f_tl_q, f_tl_d, f_tr_q, f_tr_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [2:0]          avail_q, avail_d;

    // Tag of the read whose data is on mem_rdata_i this cycle.
    logic                cap_vld_q;
    state_t              cap_state_q;
    logic [CNT_W-1:0]    cap_cnt_q;

    logic [PIX_W-1:0]    top_q  [TOP_N];
    logic [PIX_W-1:0]    left_q [MAX_BLK];
    logic [PIX_W-1:0]    tl_q;

    logic [TIDX_W-1:0]   in_n_c;
    logic                in_top_c, in_left_c, in_tl_c, in_tr_c;
    logic                accept_c, last_c;
    state_t              nxt_phase_c;
    logic [CNT_W-1:0]    nxt_cnt_c;
    logic [31:0]         rr_c, cc_c;
    logic [PIX_W-1:0]    repl_c;

    // Request decode from the raw inputs.
    always_comb begin
        case (blk_size_i)
            2'd0:    in_n_c = TIDX_W'(4);
            2'd1:    in_n_c = TIDX_W'(8);
            default: in_n_c = TIDX_W'(16);
        endcase
        in_top_c  = (blk_row_i != 16'd0);
        in_left_c = (blk_col_i != 16'd0);
        in_tl_c   = in_top_c && in_left_c;
        in_tr_c   = in_top_c && tr_avail_i &&
                    ((32'(blk_col_i) + 32'd2 * 32'(in_n_c)) <= 32'(FRAME_W));
    end

    // State and control registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            n_q        <= '0;
            f_top_q    <= 1'b0;
            f_left_q   <= 1'b0;
            f_tl_q     <= 1'b0;
            f_tr_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            avail_q    <= '0;
            cap_vld_q  <= 1'b0;
            cap_state_q <= S_IDLE;
            cap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            n_q        <= n_d;
            f_top_q    <= f_top_d;
            f_left_q   <= f_left_d;
            f_tl_q     <= f_tl_d;
            f_tr_q     <= f_tr_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            avail_q    <= avail_d;
            cap_vld_q  <= mem_rd_q;
            cap_state_q <= state_q;
            cap_cnt_q  <= cnt_q;
        end
    end

    // Next state, next read and registered outputs. The state register
    // names the phase of the read currently on the bus.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        n_d         = n_q;
        f_top_d     = f_top_q;
        f_left_d    = f_left_q;
        f_tl_d      = f_tl_q;
        f_tr_d      = f_tr_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        avail_d     = avail_q;
        accept_c    = 1'b0;
        nxt_phase_c = state_q;
        nxt_cnt_c   = '0;
        rr_c        = '0;
        cc_c        = '0;
        last_c      = (state_q == S_CORNER) ||
                      (TIDX_W'(cnt_q) == TIDX_W'(n_q - 1'b1));

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    accept_c    = 1'b1;
                    row_d       = blk_row_i;
                    col_d       = blk_col_i;
                    n_d         = in_n_c;
                    f_top_d     = in_top_c;
                    f_left_d    = in_left_c;
                    f_tl_d      = in_tl_c;
                    f_tr_d      = in_tr_c;
                    avail_d     = {in_tl_c, in_left_c, in_top_c};
                    busy_d      = 1'b1;
                    nxt_phase_c = first_phase(S_CORNER, in_tl_c, in_top_c, in_tr_c, in_left_c);
                end
            end
            S_CORNER, S_TOP, S_TR, S_LEFT: begin
                if (last_c) begin
                    nxt_phase_c = first_phase(succ_phase(state_q), f_tl_q, f_top_q, f_tr_q, f_left_q);
                end else begin
                    nxt_cnt_c = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept_c || state_q inside {S_CORNER, S_TOP, S_TR, S_LEFT}) begin
            state_d  = nxt_phase_c;
            cnt_d    = nxt_cnt_c;
            mem_rd_d = nxt_phase_c inside {S_CORNER, S_TOP, S_TR, S_LEFT};
            case (nxt_phase_c)
                S_CORNER: begin rr_c = 32'(row_d) - 32'd1; cc_c = 32'(col_d) - 32'd1; end
                S_TOP:    begin rr_c = 32'(row_d) - 32'd1; cc_c = 32'(col_d) + 32'(nxt_cnt_c); end
                S_TR:     begin rr_c = 32'(row_d) - 32'd1;
                                cc_c = 32'(col_d) + 32'(n_d) + 32'(nxt_cnt_c); end
                default:  begin rr_c = 32'(row_d) + 32'(nxt_cnt_c); cc_c = 32'(col_d) - 32'd1; end
            endcase
            if (mem_rd_d) mem_addr_d = ADDR_W'(rr_c * 32'(FRAME_W) + cc_c);
        end
    end

    // Replication source; top[N-1] may be arriving in this very cycle.
    always_comb begin
        if (cap_vld_q && cap_state_q == S_TOP &&
            TIDX_W'(cap_cnt_q) == TIDX_W'(n_q - 1'b1)) begin
            repl_c = mem_rdata_i;
        end else begin
            repl_c = top_q[n_q - 1'b1];
        end
    end

    // Neighbour storage: clear/substitute on accept, capture, replicate.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int j = 0; j < int'(TOP_N); j++)   top_q[j]  <= '0;
            for (int i = 0; i < int'(MAX_BLK); i++) left_q[i] <= '0;
            tl_q <= '0;
        end else begin
            if (accept_c) begin
                for (int j = 0; j < int'(TOP_N); j++) begin
                    if (j >= 2 * int'(in_n_c)) top_q[j] <= '0;
                    else if (!in_top_c)        top_q[j] <= PIX_W'(DEFAULT_PIX);
                end
                for (int i = 0; i < int'(MAX_BLK); i++) begin
                    if (i >= int'(in_n_c))  left_q[i] <= '0;
                    else if (!in_left_c)    left_q[i] <= PIX_W'(DEFAULT_PIX);
                end
                if (!in_tl_c) tl_q <= PIX_W'(DEFAULT_PIX);
            end
            if (cap_vld_q) begin
                case (cap_state_q)
                    S_CORNER: tl_q <= mem_rdata_i;
                    S_TOP:    top_q[TIDX_W'(cap_cnt_q)] <= mem_rdata_i;
                    S_TR:     top_q[TIDX_W'(n_q + TIDX_W'(cap_cnt_q))] <= mem_rdata_i;
                    S_LEFT:   left_q[cap_cnt_q] <= mem_rdata_i;
                    default:  ;
                endcase
            end
            if (state_q == S_DRAIN && f_top_q && !f_tr_q) begin
                for (int j = 0; j < int'(TOP_N); j++) begin
                    if (j >= int'(n_q) && j < 2 * int'(n_q)) top_q[j] <= repl_c;
                end
            end
        end
    end

    for (genvar j = 0; j < int'(TOP_N); j++) begin : g_top_out
        assign top_pix_o[j*PIX_W +: PIX_W] = top_q[j];
    end
    for (genvar i = 0; i < int'(MAX_BLK); i++) begin : g_left_out
        assign left_pix_o[i*PIX_W +: PIX_W] = left_q[i];
    end

    assign topleft_pix_o = tl_q;
    assign mem_rd_o      = mem_rd_q;
    assign mem_addr_o    = mem_addr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign avail_o       = avail_q;

endmodule

// File: tb/tb_intra_neighbour_fetch.sv
// Directed bench for intra_neighbour_fetch; memory returns (addr mod 256).
module tb_intra_neighbour_fetch;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [15:0]  blk_row, blk_col;
    logic [1:0]   blk_size;
    logic         tr_avail;
    logic         mem_rd;
    logic [19:0]  mem_addr;
    logic [7:0]   mem_rdata;
    logic         busy, done;
    logic [255:0] top_pix;
    logic [127:0] left_pix;
    logic [7:0]   topleft_pix;
    logic [2:0]   avail;

    int vecs = 0;
    int errs = 0;
    int addr_q[$];
    int exp_a[$];
    int done_cyc, busy_cyc, n_reads;
    logic any_done;

    intra_neighbour_fetch dut (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start),
        .blk_row_i(blk_row), .blk_col_i(blk_col), .blk_size_i(blk_size),
        .tr_avail_i(tr_avail), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .done_o(done),
        .top_pix_o(top_pix), .left_pix_o(left_pix),
        .topleft_pix_o(topleft_pix), .avail_o(avail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem_rd ? mem_addr[7:0] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] epx(input int r, input int c);
        return 32'((r * 1280 + c) % 256);
    endfunction

    function automatic logic [31:0] topp(input int j);
        return 32'(top_pix[j*8 +: 8]);
    endfunction

    function automatic logic [31:0] leftp(input int i);
        return 32'(left_pix[i*8 +: 8]);
    endfunction

    // One request; samples each cycle at the falling edge (cycle 1 = first after accept).
    task automatic run(input int r, input int c, input int sz, input int tr,
                       input int abort_cyc, input int glitch_cyc);
        addr_q.delete();
        done_cyc = -1; busy_cyc = 0; n_reads = 0;
        @(negedge clk);
        blk_row = 16'(r); blk_col = 16'(c); blk_size = 2'(sz); tr_avail = 1'(tr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (cyc == abort_cyc) begin
                reset_n = 1'b0;
                return;
            end
            if (cyc == glitch_cyc) begin
                start = 1'b1; blk_row = 16'd0; blk_col = 16'd0; blk_size = 2'd0;
            end
            if (mem_rd) begin
                addr_q.push_back(int'(mem_addr));
                n_reads++;
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            if (cyc == glitch_cyc) start = 1'b0;
        end
    endtask

    task automatic chk_addrs(input string tag);
        for (int k = 0; k < exp_a.size(); k++)
            chk(tag, (k < addr_q.size()) ? 32'(addr_q[k]) : 32'hFFFF_FFFF, 32'(exp_a[k]));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; blk_row = '0; blk_col = '0;
        blk_size = '0; tr_avail = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd", 32'(mem_rd), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_avail", 32'(avail), 0);
        chk("rst_pix", 32'(|{top_pix, left_pix, topleft_pix}), 0);
        reset_n = 1'b1;

        // 1: frame corner, nothing available
        run(0, 0, 2, 0, -1, -1);
        chk("s1_done_cyc", 32'(done_cyc), 2);
        chk("s1_reads", 32'(n_reads), 0);
        chk("s1_busy_cyc", 32'(busy_cyc), 1);
        chk("s1_avail", 32'(avail), 0);
        for (int j = 0; j < 32; j++) chk("s1_top", topp(j), 128);
        for (int i = 0; i < 16; i++) chk("s1_left", leftp(i), 128);
        chk("s1_tl", 32'(topleft_pix), 128);
        @(negedge clk);
        chk("s1_done_pulse", 32'(done), 0);

        // 2: everything available, 49 reads
        run(16, 16, 2, 1, -1, -1);
        chk("s2_reads", 32'(n_reads), 49);
        exp_a.delete();
        exp_a.push_back(15 * 1280 + 15);
        for (int j = 0; j < 32; j++) exp_a.push_back(15 * 1280 + 16 + j);
        for (int i = 0; i < 16; i++) exp_a.push_back((16 + i) * 1280 + 15);
        chk_addrs("s2_addr");
        chk("s2_done_cyc", 32'(done_cyc), 51);
        chk("s2_busy_cyc", 32'(busy_cyc), 50);
        chk("s2_avail", 32'(avail), 7);
        for (int j = 0; j < 32; j++) chk("s2_top", topp(j), epx(15, 16 + j));
        for (int i = 0; i < 16; i++) chk("s2_left", leftp(i), epx(16 + i, 15));
        chk("s2_tl", 32'(topleft_pix), epx(15, 15));

        // 3: 4x4, top-right replicated
        run(4, 4, 0, 0, -1, -1);
        chk("s3_reads", 32'(n_reads), 9);
        chk("s3_done_cyc", 32'(done_cyc), 11);
        chk("s3_busy_cyc", 32'(busy_cyc), 10);
        chk("s3_avail", 32'(avail), 7);
        for (int j = 0; j < 32; j++)
            chk("s3_top", topp(j), (j < 4) ? epx(3, 4 + j) : (j < 8) ? epx(3, 7) : 32'd0);
        for (int i = 0; i < 16; i++)
            chk("s3_left", leftp(i), (i < 4) ? epx(4 + i, 3) : 32'd0);
        chk("s3_tl", 32'(topleft_pix), epx(3, 3));

        // 4: right frame edge suppresses top-right
        run(8, 1272, 1, 1, -1, -1);
        chk("s4_reads", 32'(n_reads), 17);
        chk("s4_done_cyc", 32'(done_cyc), 19);
        chk("s4_avail", 32'(avail), 7);
        for (int j = 0; j < 32; j++)
            chk("s4_top", topp(j), (j < 8) ? epx(7, 1272 + j) : (j < 16) ? epx(7, 1279) : 32'd0);
        for (int i = 0; i < 8; i++) chk("s4_left", leftp(i), epx(8 + i, 1271));
        chk("s4_tl", 32'(topleft_pix), epx(7, 1271));

        // 5: left edge, top-only, start pulsed mid-fetch
        run(32, 0, 1, 0, -1, 3);
        chk("s5_reads", 32'(n_reads), 8);
        chk("s5_done_cyc", 32'(done_cyc), 10);
        chk("s5_avail", 32'(avail), 1);
        exp_a.delete();
        for (int j = 0; j < 8; j++) exp_a.push_back(31 * 1280 + j);
        chk_addrs("s5_addr");
        for (int j = 0; j < 32; j++)
            chk("s5_top", topp(j), (j < 8) ? epx(31, j) : (j < 16) ? epx(31, 7) : 32'd0);
        for (int i = 0; i < 16; i++) chk("s5_left", leftp(i), (i < 8) ? 32'd128 : 32'd0);
        chk("s5_tl", 32'(topleft_pix), 128);
        @(negedge clk);
        chk("s5_idle_after", 32'(busy), 0);

        // 6: reset in cycle 5 of a full fetch
        run(16, 16, 2, 1, 5, -1);
        #1;
        chk("s6_rd", 32'(mem_rd), 0);
        chk("s6_addr", 32'(mem_addr), 0);
        chk("s6_busy", 32'(busy), 0);
        chk("s6_done", 32'(done), 0);
        chk("s6_avail", 32'(avail), 0);
        chk("s6_pix", 32'(|{top_pix, left_pix, topleft_pix}), 0);
        any_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_done = any_done | done;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            any_done = any_done | done;
        end
        chk("s6_no_done", 32'(any_done), 0);
        run(4, 4, 0, 0, -1, -1);
        chk("s6_re_reads", 32'(n_reads), 9);
        chk("s6_re_done_cyc", 32'(done_cyc), 11);
        chk("s6_re_top5", topp(5), epx(3, 7));
        chk("s6_re_left2", leftp(2), epx(6, 3));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
